// File: rtl/lsu_pkg.sv
// Package for the load/store unit.
// Holds the RV32I funct3 width/sign codes for loads and stores, the FSM
// state type, and the data-memory bus widths.
package lsu_pkg;

    localparam int XLEN = 32;
    localparam int STRB = XLEN / 8;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_mem_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// Handshake: the master holds mem_req=1 with mem_we/mem_addr/mem_wdata/
// mem_wstrb stable until a cycle in which the slave drives mem_ready=1; that
// cycle completes the access, and for reads mem_rdata is valid in it.
//   mem_req    master->slave  access request
//   mem_we     master->slave  1 = write
//   mem_addr   master->slave  word-aligned byte address
//   mem_wdata  master->slave  lane-shifted write data
//   mem_wstrb  master->slave  byte strobes (0 for reads)
//   mem_ready  slave->master  access accepted/completed this cycle
//   mem_rdata  slave->master  read word, valid with mem_ready
interface lsu_mem_if;
    import lsu_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [STRB-1:0]   mem_wstrb;
    logic              mem_ready;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
//   is_store, funct3, addr_lo  access kind, width/sign, low address bits
//   store_data                 rs2 value
//   rdata                      raw memory read word
//   wstrb, wdata               byte strobes and replicated store data
//   load_ext                   selected and extended load value
//   legal                      funct3 is a valid code for this access kind
//   aligned                    address is aligned for the access width
// Width for the alignment test comes from funct3[1:0], so an illegal code
// still has a width; that lets misaligned take priority over fault.
module lsu_align
    import lsu_pkg::*;
(
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    output logic [STRB-1:0] wstrb,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_ext,
    output logic            legal,
    output logic            aligned
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        legal = 1'b0;
        if (is_store) begin
            legal = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        end else begin
            legal = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                    (funct3 == F3_LBU) || (funct3 == F3_LHU);
        end
    end

    always_comb begin
        aligned = 1'b1;
        case (funct3[1:0])
            2'b01:   aligned = ~addr_lo[0];
            2'b10:   aligned = (addr_lo == 2'b00);
            2'b11:   aligned = (addr_lo == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    always_comb begin
        wstrb = '0;
        wdata = store_data;
        if (is_store) begin
            case (funct3)
                F3_SB: begin
                    wstrb = 4'b0001 << addr_lo;
                    wdata = {4{store_data[7:0]}};
                end
                F3_SH: begin
                    wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata = {2{store_data[15:0]}};
                end
                F3_SW: begin
                    wstrb = 4'b1111;
                    wdata = store_data;
                end
                default: begin
                    wstrb = '0;
                    wdata = store_data;
                end
            endcase
        end
    end

    always_comb begin
        case (addr_lo)
            2'd0:    rd_byte = rdata[7:0];
            2'd1:    rd_byte = rdata[15:8];
            2'd2:    rd_byte = rdata[23:16];
            default: rd_byte = rdata[31:24];
        endcase
        rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        load_ext = '0;
        case (funct3)
            F3_LB:   load_ext = {{24{rd_byte[7]}}, rd_byte};
            F3_LH:   load_ext = {{16{rd_half[15]}}, rd_half};
            F3_LW:   load_ext = rdata;
            F3_LBU:  load_ext = {24'd0, rd_byte};
            F3_LHU:  load_ext = {16'd0, rd_half};
            default: load_ext = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory access stage for the RV32I core.
// Accepts a load/store from execute, runs one access on the memory bus and
// returns byte-aligned, sign/zero-extended load data. Misaligned or illegal
// accesses are flagged with a one-cycle pulse and never reach the bus.
//   clk, rst     clock, synchronous active-high reset
//   start        execute presents an op (held while stall=1)
//   is_store     1 = store, 0 = load
//   funct3       width/sign field
//   addr         byte address
//   store_data   rs2 value
//   load_data    extended load result, valid with done
//   stall        core must hold state this cycle
//   done         one-cycle pulse, access complete
//   misaligned   one-cycle pulse, address misaligned
//   fault        one-cycle pulse, illegal funct3 or bus timeout
//   state_dbg    current FSM state
//   mem          data-memory bus (master side)
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] load_data,
    output logic            stall,
    output logic            done,
    output logic            misaligned,
    output logic            fault,
    output lsu_state_t      state_dbg,
    lsu_mem_if.master       mem
);

    // A zero-cycle budget still needs a one-bit counter to declare.
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    lsu_state_t state, state_next;

    logic [CW-1:0]   count;
    logic [2:0]      funct3_q;
    logic [1:0]      addr_lo_q;
    logic            is_store_q;

    logic            latch_en;
    logic            capture_en;
    logic            mis_set;
    logic            fault_set;
    logic            timeout_hit;

    logic [2:0]      sel_funct3;
    logic [1:0]      sel_addr_lo;
    logic            sel_is_store;
    logic [STRB-1:0] a_wstrb;
    logic [XLEN-1:0] a_wdata;
    logic [XLEN-1:0] a_load_ext;
    logic            a_legal;
    logic            a_aligned;

    // In IDLE the lane logic checks and shifts the incoming op; once an
    // access is in flight it extracts read data using the latched fields.
    assign sel_funct3   = (state == IDLE) ? funct3   : funct3_q;
    assign sel_addr_lo  = (state == IDLE) ? addr[1:0] : addr_lo_q;
    assign sel_is_store = (state == IDLE) ? is_store : is_store_q;

    lsu_align u_align (
        .is_store   (sel_is_store),
        .funct3     (sel_funct3),
        .addr_lo    (sel_addr_lo),
        .store_data (store_data),
        .rdata      (mem.mem_rdata),
        .wstrb      (a_wstrb),
        .wdata      (a_wdata),
        .load_ext   (a_load_ext),
        .legal      (a_legal),
        .aligned    (a_aligned)
    );

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            assign timeout_hit = (count == CW'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        latch_en   = 1'b0;
        capture_en = 1'b0;
        mis_set    = 1'b0;
        fault_set  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (!a_aligned) begin
                        mis_set = 1'b1;
                    end else if (!a_legal) begin
                        fault_set = 1'b1;
                    end else begin
                        latch_en   = 1'b1;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                if (mem.mem_ready) begin
                    capture_en = ~is_store_q;
                    state_next = RESP;
                end else if (timeout_hit) begin
                    fault_set  = 1'b1;
                    state_next = IDLE;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign stall        = ((state == IDLE) && start && a_legal && a_aligned) || (state == REQ);
    assign done         = (state == RESP);
    assign mem.mem_req  = (state == REQ);
    assign state_dbg    = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            load_data     <= '0;
            misaligned    <= 1'b0;
            fault         <= 1'b0;
            count         <= '0;
            funct3_q      <= '0;
            addr_lo_q     <= '0;
            is_store_q    <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_wstrb <= '0;
        end else begin
            misaligned <= mis_set;
            fault      <= fault_set;
            if (latch_en) begin
                count         <= '0;
                funct3_q      <= funct3;
                addr_lo_q     <= addr[1:0];
                is_store_q    <= is_store;
                mem.mem_we    <= is_store;
                mem.mem_addr  <= {addr[XLEN-1:2], 2'b00};
                mem.mem_wdata <= a_wdata;
                mem.mem_wstrb <= a_wstrb;
            end else if ((state == REQ) && !mem.mem_ready) begin
                count <= count + 1'b1;
            end
            if (capture_en) begin
                load_data <= a_load_ext;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam logic [1:0] K_DONE  = 2'd0;
    localparam logic [1:0] K_MIS   = 2'd1;
    localparam logic [1:0] K_FAULT = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A (default timeout) ----------------
    logic        start, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic [31:0] load_data;
    logic        stall, done, misaligned, fault;
    lsu_state_t  state_dbg;
    lsu_mem_if   bus_a ();

    load_store_unit #(.TIMEOUT_CYCLES(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .load_data  (load_data),
        .stall      (stall),
        .done       (done),
        .misaligned (misaligned),
        .fault      (fault),
        .state_dbg  (state_dbg),
        .mem        (bus_a.master)
    );

    // ---------------- DUT B (short timeout) ----------------
    logic        b_start, b_is_store;
    logic [2:0]  b_funct3;
    logic [31:0] b_addr, b_store_data;
    logic [31:0] b_load_data;
    logic        b_stall, b_done, b_misaligned, b_fault;
    lsu_state_t  b_state_dbg;
    lsu_mem_if   bus_b ();

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk        (clk),
        .rst        (rst),
        .start      (b_start),
        .is_store   (b_is_store),
        .funct3     (b_funct3),
        .addr       (b_addr),
        .store_data (b_store_data),
        .load_data  (b_load_data),
        .stall      (b_stall),
        .done       (b_done),
        .misaligned (b_misaligned),
        .fault      (b_fault),
        .state_dbg  (b_state_dbg),
        .mem        (bus_b.master)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [33:0] exp_q[$];
    logic [31:0] last_ld;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done/misaligned/fault pulse on DUT A pops one expectation.
    always @(negedge clk) begin
        logic [1:0]  obs_kind;
        logic [33:0] e;
        if (!rst && (done || misaligned || fault)) begin
            obs_kind = done ? K_DONE : (misaligned ? K_MIS : K_FAULT);
            check("single_pulse", 32'(done) + 32'(misaligned) + 32'(fault), 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got kind %0d expected none at %0t", obs_kind, $time);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", 32'(obs_kind), 32'(e[33:32]));
                if (done) check("load_data", load_data, e[31:0]);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one op on DUT A. For accesses, mem_ready is held low for 'delay'
    // REQ cycles and then raised with 'rd'.
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input int delay, input logic [31:0] rd,
                          input logic [1:0] kind, input logic [31:0] exp_data,
                          input logic access, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wdata);
        exp_q.push_back({kind, exp_data});
        tick();
        start      = 1'b1;
        is_store   = st;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        bus_a.mem_ready = 1'b0;
        #1;
        check("stall_start", stall, access);
        if (!access) begin
            tick();
            start = 1'b0;
            check("no_req_c1", bus_a.mem_req, 1'b0);
            tick();
            check("no_req_c2", bus_a.mem_req, 1'b0);
            check("no_stall", stall, 1'b0);
        end else begin
            tick();
            check("req_up", bus_a.mem_req, 1'b1);
            check("stall_req", stall, 1'b1);
            check("mem_addr", bus_a.mem_addr, {a[31:2], 2'b00});
            check("mem_we", bus_a.mem_we, st);
            check("mem_wstrb", 32'(bus_a.mem_wstrb), 32'(exp_strb));
            if (st) check("mem_wdata", bus_a.mem_wdata, exp_wdata);
            for (int i = 0; i < delay; i++) begin
                tick();
                check("wait_stall", stall, 1'b1);
                check("wait_req", bus_a.mem_req, 1'b1);
                check("wait_addr", bus_a.mem_addr, {a[31:2], 2'b00});
                if (st) check("wait_wdata", bus_a.mem_wdata, exp_wdata);
                check("wait_no_done", done, 1'b0);
            end
            bus_a.mem_ready = 1'b1;
            bus_a.mem_rdata = rd;
            tick();
            bus_a.mem_ready = 1'b0;
            start = 1'b0;
            check("resp_done", done, 1'b1);
            check("resp_stall", stall, 1'b0);
            check("resp_req", bus_a.mem_req, 1'b0);
        end
    endtask

    task automatic load_op(input logic [2:0] f3, input logic [31:0] a, input int delay,
                           input logic [31:0] rd, input logic [31:0] exp_data);
        last_ld = exp_data;
        run_op(1'b0, f3, a, 32'h0, delay, rd, K_DONE, exp_data, 1'b1, 4'b0000, 32'h0);
    endtask

    task automatic store_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                            input logic [3:0] strb, input logic [31:0] wd);
        run_op(1'b1, f3, a, sd, 0, 32'h0, K_DONE, last_ld, 1'b1, strb, wd);
    endtask

    task automatic reject_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                             input logic [1:0] kind);
        run_op(st, f3, a, 32'h0, 0, 32'h0, kind, 32'h0, 1'b0, 4'b0000, 32'h0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int req_cycles;
        logic seen_fault;
        logic seen_done;

        rst = 1'b1;
        start = 1'b0; is_store = 1'b0; funct3 = 3'b0; addr = 32'h0; store_data = 32'h0;
        b_start = 1'b0; b_is_store = 1'b0; b_funct3 = 3'b0; b_addr = 32'h0; b_store_data = 32'h0;
        bus_a.mem_ready = 1'b0; bus_a.mem_rdata = 32'h0;
        bus_b.mem_ready = 1'b0; bus_b.mem_rdata = 32'h0;
        last_ld = 32'h0;
        repeat (3) tick();
        rst = 1'b0;
        #1;

        check("rst_state", 32'(state_dbg), 32'(IDLE));
        check("rst_load_data", load_data, 32'h0);
        check("rst_done", done, 1'b0);
        check("rst_misaligned", misaligned, 1'b0);
        check("rst_fault", fault, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_mem_req", bus_a.mem_req, 1'b0);
        check("rst_mem_we", bus_a.mem_we, 1'b0);
        check("rst_mem_addr", bus_a.mem_addr, 32'h0);
        check("rst_mem_wdata", bus_a.mem_wdata, 32'h0);
        check("rst_mem_wstrb", 32'(bus_a.mem_wstrb), 32'h0);
        check("rst_b_mem_req", bus_b.mem_req, 1'b0);

        // Loads with hand-computed extraction
        load_op(F3_LW,  32'h0000_0100, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        load_op(F3_LB,  32'h0000_0103, 0, 32'h80FF_1234, 32'hFFFF_FF80);
        load_op(F3_LBU, 32'h0000_0103, 0, 32'h80FF_1234, 32'h0000_0080);
        load_op(F3_LHU, 32'h0000_0102, 0, 32'h80FF_1234, 32'h0000_80FF);
        load_op(F3_LH,  32'h0000_0100, 1, 32'h0000_F00D, 32'hFFFF_F00D);
        load_op(F3_LB,  32'h0000_0101, 0, 32'h0000_7F00, 32'h0000_007F);

        // Stores: lanes, and load_data left unchanged
        store_op(F3_SB, 32'h0000_0201, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB);
        store_op(F3_SH, 32'h0000_0202, 32'h0000_CAFE, 4'b1100, 32'hCAFE_CAFE);
        store_op(F3_SW, 32'h0000_0300, 32'h1234_5678, 4'b1111, 32'h1234_5678);
        store_op(F3_SB, 32'h0000_0200, 32'hFFFF_FF5A, 4'b0001, 32'h5A5A_5A5A);

        // Rejected ops: never reach the bus
        reject_op(1'b0, F3_LW,  32'h0000_0102, K_MIS);
        reject_op(1'b0, 3'b011, 32'h0000_0100, K_FAULT);
        reject_op(1'b1, 3'b100, 32'h0000_0200, K_FAULT);
        reject_op(1'b0, F3_LH,  32'h0000_0105, K_MIS);
        reject_op(1'b0, 3'b110, 32'h0000_0101, K_MIS);

        // Slow memory: ready held low for 5 cycles
        load_op(F3_LW, 32'h0000_0400, 5, 32'h0BAD_F00D, 32'h0BAD_F00D);

        // Reset while an access is outstanding
        tick();
        start = 1'b1; is_store = 1'b0; funct3 = F3_LW; addr = 32'h0000_0500;
        bus_a.mem_ready = 1'b0;
        tick();
        start = 1'b0;
        check("abandon_req", bus_a.mem_req, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("abandon_mem_req", bus_a.mem_req, 1'b0);
        check("abandon_done", done, 1'b0);
        check("abandon_state", 32'(state_dbg), 32'(IDLE));
        check("abandon_load_data", load_data, 32'h0);
        check("abandon_mem_addr", bus_a.mem_addr, 32'h0);
        check("abandon_stall", stall, 1'b0);
        last_ld = 32'h0;

        load_op(F3_LW, 32'h0000_0104, 0, 32'h55AA_55AA, 32'h55AA_55AA);

        // Bus timeout on DUT B (4-cycle budget, ready never asserted)
        tick();
        b_start = 1'b1; b_is_store = 1'b0; b_funct3 = F3_LW; b_addr = 32'h0000_0010;
        tick();
        b_start = 1'b0;
        req_cycles = 0;
        seen_fault = 1'b0;
        seen_done  = 1'b0;
        for (int i = 0; i < 12 && !seen_fault; i++) begin
            if (bus_b.mem_req) req_cycles++;
            if (b_done) seen_done = 1'b1;
            if (b_fault) seen_fault = 1'b1;
            else tick();
        end
        check("timeout_fault", seen_fault, 1'b1);
        check("timeout_req_cycles", 32'(req_cycles), 32'd4);
        check("timeout_no_done", seen_done, 1'b0);
        check("timeout_state", 32'(b_state_dbg), 32'(IDLE));
        check("timeout_mem_req", bus_b.mem_req, 1'b0);
        tick();
        check("timeout_pulse_len", b_fault, 1'b0);

        repeat (3) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
